// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared constants and FSM state encoding for the arithmetic
//               issue path. Imported by the decoder and the sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package arith_pkg;

    // Instruction byte fields: [7:6] mode, [5:3] sub-mode, [2:0] op
    localparam logic [1:0] MODE_ARITH    = 2'b01;
    localparam logic [2:0] SUBMODE_ARITH = 3'b000;
    localparam logic [2:0] OP_ADD        = 3'b100;
    localparam logic [2:0] OP_SUB        = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/arith_issue_decode.sv
`default_nettype none
// ============================================================================
// Module      : arith_issue_decode
// Description : Combinational instruction-byte decoder for arithmetic mode.
//               A byte is legal only when mode, sub-mode and op all match a
//               supported arithmetic instruction.
// Ports       : i_instr  [7:0]  instruction byte
//               o_legal         byte is a supported arithmetic instruction
//               o_op     [2:0]  op field (meaningful only when o_legal=1)
// Revision    : 1.0  initial release
// ============================================================================
module arith_issue_decode
    import arith_pkg::*;
(
    input  logic [7:0] i_instr,
    output logic       o_legal,
    output logic [2:0] o_op
);

    logic w_mode_ok;
    logic w_sub_ok;
    logic w_op_ok;

    assign w_mode_ok = (i_instr[7:6] == MODE_ARITH);
    assign w_sub_ok  = (i_instr[5:3] == SUBMODE_ARITH);
    assign w_op_ok   = (i_instr[2:0] == OP_ADD) || (i_instr[2:0] == OP_SUB);

    assign o_legal = w_mode_ok && w_sub_ok && w_op_ok;
    assign o_op    = i_instr[2:0];

endmodule : arith_issue_decode
`default_nettype wire

// File: rtl/arith_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : arith_issue_sequencer
// Description : Multi-cycle issue sequencer for arithmetic instructions.
//               IDLE -> READ_A -> READ_B -> EXEC -> WRITE -> IDLE.
//               Accepts an instruction byte, reads two source registers,
//               drives the external combinational ALU and writes back.
// Options     : ARITH_SEQ_OVERFLOW_EN - when defined, signed overflow is
//               computed in EXEC and presented with done; otherwise the
//               overflow output is tied low.
// Ports       : clock, resetN (sync, active-low)
//               instrValid/instrReady/instr   instruction handshake
//               regReadAddr/regReadData       register-file read (comb.)
//               regWriteEn/Addr/Data          register-file write
//               aluOpcode/OperandA/OperandB   to ALU; aluResult from ALU
//               done, illegal, overflow       status pulses
// Revision    : 1.0  initial release
// ============================================================================
module arith_issue_sequencer
    import arith_pkg::*;
#(
    parameter logic [2:0] SRC_A_ADDR = 3'd0,
    parameter logic [2:0] SRC_B_ADDR = 3'd1,
    parameter logic [2:0] DST_ADDR   = 3'd2
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              instrValid,
    output logic              instrReady,
    input  logic [7:0]        instr,
    output logic [2:0]        regReadAddr,
    input  logic [7:0]        regReadData,
    output logic              regWriteEn,
    output logic [2:0]        regWriteAddr,
    output logic [7:0]        regWriteData,
    output logic [2:0]        aluOpcode,
    output logic signed [7:0] aluOperandA,
    output logic signed [7:0] aluOperandB,
    input  logic signed [7:0] aluResult,
    output logic              done,
    output logic              illegal,
    output logic              overflow
);

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_opcode;
    logic signed [7:0] r_op_a;
    logic signed [7:0] r_op_b;
    logic [7:0]        r_result;
    logic              r_illegal;

    logic              w_legal;
    logic [2:0]        w_op;
    logic              w_handshake;
    logic [2:0]        w_read_addr;
    logic              w_write;

    arith_issue_decode u_decode (
        .i_instr (instr),
        .o_legal (w_legal),
        .o_op    (w_op)
    );

    // Ready is gated by resetN so it drops in the same cycle reset asserts.
    assign instrReady  = (r_state == ST_IDLE) && resetN;
    assign w_handshake = instrValid && instrReady;

`ifdef ARITH_SEQ_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf;

    // ADD: like-signed operands, result sign flips.
    // SUB: unlike-signed operands, result sign differs from A.
    always_comb begin
        w_ovf = 1'b0;
        if (r_opcode == OP_ADD) begin
            w_ovf = (r_op_a[7] == r_op_b[7]) && (aluResult[7] != r_op_a[7]);
        end else if (r_opcode == OP_SUB) begin
            w_ovf = (r_op_a[7] != r_op_b[7]) && (aluResult[7] != r_op_a[7]);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf && w_write && resetN;
`else
    assign overflow = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state   <= ST_IDLE;
            r_opcode  <= 3'b000;
            r_op_a    <= 8'sd0;
            r_op_b    <= 8'sd0;
            r_result  <= 8'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_handshake && !w_legal;
            case (r_state)
                ST_IDLE:   if (w_handshake && w_legal) r_opcode <= w_op;
                ST_READ_A: r_op_a   <= regReadData;
                ST_READ_B: r_op_b   <= regReadData;
                ST_EXEC:   r_result <= aluResult;
                default:   ;
            endcase
        end
    end

    // Next-state and per-state outputs
    always_comb begin
        w_next      = r_state;
        w_read_addr = SRC_A_ADDR;
        w_write     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake && w_legal) w_next = ST_READ_A;
            end
            ST_READ_A: begin
                w_next = ST_READ_B;
            end
            ST_READ_B: begin
                w_read_addr = SRC_B_ADDR;
                w_next      = ST_EXEC;
            end
            ST_EXEC: begin
                w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_write = 1'b1;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign regReadAddr  = w_read_addr;
    assign regWriteEn   = w_write && resetN;
    assign regWriteAddr = DST_ADDR;
    assign regWriteData = r_result;
    assign done         = w_write && resetN;
    assign illegal      = r_illegal && resetN;
    assign aluOpcode    = r_opcode;
    assign aluOperandA  = r_op_a;
    assign aluOperandB  = r_op_b;

endmodule : arith_issue_sequencer
`default_nettype wire

// File: tb/tb_arith_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_issue_sequencer
// Description : Directed self-checking bench for arith_issue_sequencer with a
//               behavioural register file and ALU.
// Revision    : 1.0  initial release
// ============================================================================
module tb_arith_issue_sequencer;

    logic              clock;
    logic              resetN;
    logic              instrValid;
    logic              instrReady;
    logic [7:0]        instr;
    logic [2:0]        regReadAddr;
    logic [7:0]        regReadData;
    logic              regWriteEn;
    logic [2:0]        regWriteAddr;
    logic [7:0]        regWriteData;
    logic [2:0]        aluOpcode;
    logic signed [7:0] aluOperandA;
    logic signed [7:0] aluOperandB;
    logic signed [7:0] aluResult;
    logic              done;
    logic              illegal;
    logic              overflow;

    logic [7:0] regs [8];
    int n_pass;
    int n_total;

    arith_issue_sequencer dut (
        .clock        (clock),
        .resetN       (resetN),
        .instrValid   (instrValid),
        .instrReady   (instrReady),
        .instr        (instr),
        .regReadAddr  (regReadAddr),
        .regReadData  (regReadData),
        .regWriteEn   (regWriteEn),
        .regWriteAddr (regWriteAddr),
        .regWriteData (regWriteData),
        .aluOpcode    (aluOpcode),
        .aluOperandA  (aluOperandA),
        .aluOperandB  (aluOperandB),
        .aluResult    (aluResult),
        .done         (done),
        .illegal      (illegal),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign regReadData = regs[regReadAddr];

    always @(posedge clock) begin
        if (regWriteEn) regs[regWriteAddr] <= regWriteData;
    end

    always_comb begin
        aluResult = 8'sd0;
        if (aluOpcode == 3'b100)      aluResult = aluOperandA + aluOperandB;
        else if (aluOpcode == 3'b101) aluResult = aluOperandA - aluOperandB;
    end

`ifdef ARITH_SEQ_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [7:0] b);
        instr      = b;
        instrValid = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        tick();
        tick();
        n_total++; if (instrReady !== 1'b0) $display("FAIL rst_ready got=%b exp=0", instrReady); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done got=%b exp=0", done); else n_pass++;
        n_total++; if (illegal !== 1'b0) $display("FAIL rst_illegal got=%b exp=0", illegal); else n_pass++;
        n_total++; if (regWriteEn !== 1'b0) $display("FAIL rst_wen got=%b exp=0", regWriteEn); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", overflow); else n_pass++;
        n_total++; if (aluOpcode !== 3'b000) $display("FAIL rst_opcode got=%h exp=0", aluOpcode); else n_pass++;
        n_total++; if ({aluOperandA, aluOperandB} !== 16'h0000) $display("FAIL rst_operands got=%h exp=0", {aluOperandA, aluOperandB}); else n_pass++;
        resetN = 1'b1;
        #1;
        n_total++; if (instrReady !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", instrReady); else n_pass++;
    endtask

    task automatic test_add();
        regs[0] = 8'd5; regs[1] = 8'd3; regs[2] = 8'h00;
        offer(8'h44);
        tick();  // cycle 1
        instrValid = 1'b0;
        n_total++; if (regReadAddr !== 3'd0) $display("FAIL add_rdaddr_a got=%0d exp=0", regReadAddr); else n_pass++;
        n_total++; if (aluOpcode !== 3'b100) $display("FAIL add_opcode got=%b exp=100", aluOpcode); else n_pass++;
        n_total++; if (instrReady !== 1'b0) $display("FAIL add_busy got=%b exp=0", instrReady); else n_pass++;
        tick();  // cycle 2
        n_total++; if (regReadAddr !== 3'd1) $display("FAIL add_rdaddr_b got=%0d exp=1", regReadAddr); else n_pass++;
        n_total++; if (aluOperandA !== 8'sd5) $display("FAIL add_opA got=%0d exp=5", aluOperandA); else n_pass++;
        tick();  // cycle 3
        n_total++; if (aluOperandB !== 8'sd3) $display("FAIL add_opB got=%0d exp=3", aluOperandB); else n_pass++;
        n_total++; if (regWriteEn !== 1'b0) $display("FAIL add_wen_early got=%b exp=0", regWriteEn); else n_pass++;
        tick();  // cycle 4
        n_total++; if (regWriteEn !== 1'b1) $display("FAIL add_wen got=%b exp=1", regWriteEn); else n_pass++;
        n_total++; if (regWriteAddr !== 3'd2) $display("FAIL add_waddr got=%0d exp=2", regWriteAddr); else n_pass++;
        n_total++; if (regWriteData !== 8'h08) $display("FAIL add_wdata got=%h exp=08", regWriteData); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL add_done got=%b exp=1", done); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL add_ovf got=%b exp=0", overflow); else n_pass++;
        tick();  // cycle 5
        n_total++; if (instrReady !== 1'b1) $display("FAIL add_ready_c5 got=%b exp=1", instrReady); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL add_done_c5 got=%b exp=0", done); else n_pass++;
        n_total++; if (regs[2] !== 8'h08) $display("FAIL add_regfile got=%h exp=08", regs[2]); else n_pass++;
    endtask

    task automatic test_sub();
        regs[0] = 8'd5; regs[1] = 8'd7;
        offer(8'h45);
        tick();
        instrValid = 1'b0;
        tick(); tick(); tick();  // cycle 4
        n_total++; if (regWriteData !== 8'hFE) $display("FAIL sub_wdata got=%h exp=FE", regWriteData); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL sub_done got=%b exp=1", done); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL sub_ovf got=%b exp=0", overflow); else n_pass++;
        tick();
    endtask

    task automatic test_illegal();
        offer(8'h86);
        tick();  // cycle 1: pulse for 86, next byte offered at end of cycle
        n_total++; if (illegal !== 1'b1) $display("FAIL ill86_pulse got=%b exp=1", illegal); else n_pass++;
        n_total++; if (instrReady !== 1'b1) $display("FAIL ill86_ready got=%b exp=1", instrReady); else n_pass++;
        n_total++; if (regWriteEn !== 1'b0) $display("FAIL ill86_wen got=%b exp=0", regWriteEn); else n_pass++;
        offer(8'h46);
        tick();  // cycle 2: pulse for 46
        instrValid = 1'b0;
        n_total++; if (illegal !== 1'b1) $display("FAIL ill46_pulse got=%b exp=1", illegal); else n_pass++;
        n_total++; if (instrReady !== 1'b1) $display("FAIL ill46_ready got=%b exp=1", instrReady); else n_pass++;
        tick();
        n_total++; if (illegal !== 1'b0) $display("FAIL ill_clear got=%b exp=0", illegal); else n_pass++;
        n_total++; if ({regWriteEn, done} !== 2'b00) $display("FAIL ill_nowrite got=%b exp=00", {regWriteEn, done}); else n_pass++;
        n_total++; if (instrReady !== 1'b1) $display("FAIL ill_idle got=%b exp=1", instrReady); else n_pass++;
    endtask

    task automatic test_overflow();
        regs[0] = 8'd100; regs[1] = 8'd50;
        offer(8'h44);
        tick(); instrValid = 1'b0;
        tick(); tick(); tick();
        n_total++; if (regWriteData !== 8'h96) $display("FAIL ovf_add_data got=%h exp=96", regWriteData); else n_pass++;
        n_total++; if (overflow !== OVF_ON) $display("FAIL ovf_add_flag got=%b exp=%b", overflow, OVF_ON); else n_pass++;
        tick();
        regs[0] = 8'h80; regs[1] = 8'h01;
        offer(8'h45);
        tick(); instrValid = 1'b0;
        tick(); tick(); tick();
        n_total++; if (regWriteData !== 8'h7F) $display("FAIL ovf_sub_data got=%h exp=7F", regWriteData); else n_pass++;
        n_total++; if (overflow !== OVF_ON) $display("FAIL ovf_sub_flag got=%b exp=%b", overflow, OVF_ON); else n_pass++;
        tick();
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_after got=%b exp=0", overflow); else n_pass++;
    endtask

    task automatic test_reset_mid();
        regs[0] = 8'd5; regs[1] = 8'd3; regs[2] = 8'hAA;
        offer(8'h44);
        tick(); instrValid = 1'b0;
        tick();
        tick();           // cycle 3 (EXEC)
        resetN = 1'b0;
        tick();           // cycle 4, reset took effect at the edge
        n_total++; if ({regWriteEn, done} !== 2'b00) $display("FAIL rmid_nowrite got=%b exp=00", {regWriteEn, done}); else n_pass++;
        n_total++; if (instrReady !== 1'b0) $display("FAIL rmid_ready_low got=%b exp=0", instrReady); else n_pass++;
        n_total++; if (aluOperandA !== 8'sd0) $display("FAIL rmid_opA_clr got=%0d exp=0", aluOperandA); else n_pass++;
        resetN = 1'b1;
        #1;
        n_total++; if (instrReady !== 1'b1) $display("FAIL rmid_ready_rel got=%b exp=1", instrReady); else n_pass++;
        tick();
        n_total++; if (regs[2] !== 8'hAA) $display("FAIL rmid_regfile got=%h exp=AA", regs[2]); else n_pass++;
        regs[0] = 8'd1; regs[1] = 8'd2;
        offer(8'h44);
        tick(); instrValid = 1'b0;
        tick(); tick(); tick();
        n_total++; if ({done, regWriteData} !== {1'b1, 8'h03}) $display("FAIL rmid_follow got=%b/%h exp=1/03", done, regWriteData); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int n_done;
        int first_c;
        int second_c;
        n_done = 0; first_c = -1; second_c = -1;
        regs[0] = 8'd10; regs[1] = 8'd20;
        offer(8'h44);
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                if (first_c < 0) first_c = c; else second_c = c;
            end
            if (c == 4) begin
                n_total++; if (instrReady !== 1'b0) $display("FAIL b2b_ready_c4 got=%b exp=0", instrReady); else n_pass++;
            end
            if (c == 5) begin
                n_total++; if (instrReady !== 1'b1) $display("FAIL b2b_ready_c5 got=%b exp=1", instrReady); else n_pass++;
            end
            if (c == 6) instrValid = 1'b0;
        end
        n_total++; if (n_done !== 2) $display("FAIL b2b_count got=%0d exp=2", n_done); else n_pass++;
        n_total++; if (first_c !== 4) $display("FAIL b2b_first got=%0d exp=4", first_c); else n_pass++;
        n_total++; if (second_c !== 9) $display("FAIL b2b_second got=%0d exp=9", second_c); else n_pass++;
        n_total++; if (regs[2] !== 8'd30) $display("FAIL b2b_regfile got=%h exp=1e", regs[2]); else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        resetN     = 1'b0;
        instrValid = 1'b0;
        instr      = 8'h00;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        test_reset();
        test_add();
        test_sub();
        test_illegal();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_arith_issue_sequencer
`default_nettype wire
